// File: rtl/rgb_led_driver.sv
// rtl/rgb_led_driver.sv - PWM-dimmed RGB LED driver with lights-protocol sequence checker.
// Optional wrap_pulse output enabled by defining LEDDRV_WRAP_PULSE_EN.
module rgb_led_driver #(
  parameter int PWM_BITS  = 8,
  parameter int DUTY      = 128,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           colour,
  input  logic                 enable,
  input  logic                 err_clr,
  output logic                 led_r,
  output logic                 led_g,
  output logic                 led_b,
  output logic                 seq_error,
  output logic [CNT_WIDTH-1:0] step_count
`ifdef LEDDRV_WRAP_PULSE_EN
  ,
  output logic                 wrap_pulse
`endif
);

  localparam int PERIOD = 2 ** PWM_BITS;
  // Duties beyond one period clamp to the period so the compare is always true.
  localparam logic [PWM_BITS:0] DUTY_CMP =
    (DUTY >= PERIOD) ? (PWM_BITS+1)'(PERIOD) : (PWM_BITS+1)'(DUTY);

  logic [2:0]          r_colour_q;
  logic [2:0]          r_prev_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  logic w_pwm_on;
  logic w_displayable;
  logic w_change;
  logic w_legal;
  logic w_step;
  logic w_viol;

  assign w_pwm_on      = ({1'b0, r_pwm_cnt} < DUTY_CMP);
  assign w_displayable = (r_colour_q != 3'b000) && (r_colour_q != 3'b111);
  assign w_change      = (r_colour_q != r_prev_q);

  always_comb begin
    w_legal = 1'b0;
    if ((r_prev_q >= 3'd1) && (r_prev_q <= 3'd5)) begin
      w_legal = (r_colour_q == r_prev_q + 3'd1);
    end else if (r_prev_q >= 3'd6) begin
      w_legal = (r_colour_q == 3'd1);
    end
  end

  assign w_step = w_change & w_legal;
  assign w_viol = w_change & ~w_legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_colour_q <= 3'b001;
      r_prev_q   <= 3'b001;
      r_pwm_cnt  <= '0;
      led_r      <= 1'b0;
      led_g      <= 1'b0;
      led_b      <= 1'b0;
    end else begin
      r_colour_q <= colour;
      r_prev_q   <= r_colour_q;
      r_pwm_cnt  <= enable ? r_pwm_cnt + 1'b1 : '0;
      led_r      <= r_colour_q[2] & w_pwm_on & enable & w_displayable;
      led_g      <= r_colour_q[1] & w_pwm_on & enable & w_displayable;
      led_b      <= r_colour_q[0] & w_pwm_on & enable & w_displayable;
    end
  end

  // A violation detected in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_error  <= 1'b0;
      step_count <= '0;
    end else begin
      if (w_viol) begin
        seq_error <= 1'b1;
      end else if (err_clr) begin
        seq_error <= 1'b0;
      end
      if (w_step && !(&step_count)) begin
        step_count <= step_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef LEDDRV_WRAP_PULSE_EN
  logic w_wrap_det;
  assign w_wrap_det = w_step && (r_prev_q == 3'd6);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= w_wrap_det;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_led_driver.sv
// tb/tb_rgb_led_driver.sv - scoreboard bench for rgb_led_driver across four DUTY settings.
// Honours LEDDRV_WRAP_PULSE_EN when defined.
module tb_rgb_led_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] colour = 3'd5;
  logic       enable = 1'b1;
  logic       err_clr = 1'b0;

  wire [2:0] leds128, leds0, leds256, leds64;
  wire       err128, err0, err256, err64;
  wire [7:0] cnt128, cnt0, cnt256, cnt64;
`ifdef LEDDRV_WRAP_PULSE_EN
  wire       wrap128, wrap0, wrap256, wrap64;
`endif

  always #5 clk = ~clk;

  rgb_led_driver #(.PWM_BITS(8), .DUTY(128), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable), .err_clr(err_clr),
    .led_r(leds128[2]), .led_g(leds128[1]), .led_b(leds128[0]),
    .seq_error(err128), .step_count(cnt128)
`ifdef LEDDRV_WRAP_PULSE_EN
    , .wrap_pulse(wrap128)
`endif
  );
  rgb_led_driver #(.PWM_BITS(8), .DUTY(0), .CNT_WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable), .err_clr(err_clr),
    .led_r(leds0[2]), .led_g(leds0[1]), .led_b(leds0[0]),
    .seq_error(err0), .step_count(cnt0)
`ifdef LEDDRV_WRAP_PULSE_EN
    , .wrap_pulse(wrap0)
`endif
  );
  rgb_led_driver #(.PWM_BITS(8), .DUTY(256), .CNT_WIDTH(8)) u_dut256 (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable), .err_clr(err_clr),
    .led_r(leds256[2]), .led_g(leds256[1]), .led_b(leds256[0]),
    .seq_error(err256), .step_count(cnt256)
`ifdef LEDDRV_WRAP_PULSE_EN
    , .wrap_pulse(wrap256)
`endif
  );
  rgb_led_driver #(.PWM_BITS(8), .DUTY(64), .CNT_WIDTH(8)) u_dut64 (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable), .err_clr(err_clr),
    .led_r(leds64[2]), .led_g(leds64[1]), .led_b(leds64[0]),
    .seq_error(err64), .step_count(cnt64)
`ifdef LEDDRV_WRAP_PULSE_EN
    , .wrap_pulse(wrap64)
`endif
  );

  typedef struct {
    logic [2:0] l128;
    logic [2:0] l0;
    logic [2:0] l256;
    logic [2:0] l64;
    logic       err;
    logic [7:0] cnt;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: last two sampled colours, enabled-run length, flag and counter.
  int m_col, m_prev, m_run, m_cnt;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] led_for(input int col, input bit en, input int pwm, input int duty);
    if (!en || col == 0 || col == 7 || pwm >= duty) return 3'b000;
    return 3'(col);
  endfunction

  function automatic int next_legal(input int c);
    return (c >= 1 && c <= 5) ? c + 1 : 1;
  endfunction

  task automatic model_reset();
    m_col = 1; m_prev = 1; m_run = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic step(input int c, input bit en, input bit clr, input bit rstn);
    exp_t e;
    int pwm;
    bit legal;
    @(negedge clk);
    #1;
    colour  = 3'(c);
    enable  = en;
    err_clr = clr;
    rst     = rstn;
    if (!rstn) begin
      model_reset();
      e = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 8'd0, 1'b0};
    end else begin
      pwm    = m_run % 256;
      e.l128 = led_for(m_col, en, pwm, 128);
      e.l0   = led_for(m_col, en, pwm, 0);
      e.l256 = led_for(m_col, en, pwm, 256);
      e.l64  = led_for(m_col, en, pwm, 64);
      e.wrap = 1'b0;
      if (m_col != m_prev) begin
        legal = (m_col == next_legal(m_prev)) && (m_prev != 0);
        if (legal) begin
          if (m_cnt < 255) m_cnt++;
          e.wrap = (m_prev == 6);
        end else begin
          m_err = 1;
        end
        if (clr && legal) m_err = 0;
      end else if (clr) begin
        m_err = 0;
      end
      e.err  = m_err;
      e.cnt  = 8'(m_cnt);
      m_prev = m_col;
      m_col  = c;
      m_run  = en ? m_run + 1 : 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input int c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("leds_duty128", 32'(leds128), 32'(e.l128));
        chk("leds_duty0",   32'(leds0),   32'(e.l0));
        chk("leds_duty256", 32'(leds256), 32'(e.l256));
        chk("leds_duty64",  32'(leds64),  32'(e.l64));
        chk("seq_error",    32'(err128),  32'(e.err));
        chk("step_count",   32'(cnt128),  32'(e.cnt));
`ifdef LEDDRV_WRAP_PULSE_EN
        chk("wrap_pulse",   32'(wrap128), 32'(e.wrap));
`endif
      end
    end
  end

  initial begin : stimulus
    int cur, on0, on256, on64, n;
    model_reset();
    // Reset held with colour 5, then release.
    for (int i = 0; i < 3; i++) step(5, 1'b1, 1'b0, 1'b0);
    hold(5, 4);
    // Full legal cycle after clearing the 1->5 / 5->1 violations.
    hold(1, 3);
    step(1, 1'b1, 1'b1, 1'b1);
    step(1, 1'b1, 1'b1, 1'b1);
    for (int c = 2; c <= 6; c++) hold(c, 3);
    hold(1, 3);
    // Violations: skip, clear, decrement, clear racing a move to 0.
    hold(2, 3);
    hold(4, 3);
    step(4, 1'b1, 1'b1, 1'b1);
    hold(3, 3);
    step(0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b1);
    hold(0, 2);
    // PWM extremes on green.
    hold(2, 4);
    on0 = 0; on256 = 0; on64 = 0;
    for (int i = 0; i < 512; i++) begin
      step(2, 1'b1, 1'b0, 1'b1);
      on0   += int'(leds0[1]);
      on256 += int'(leds256[1]);
      on64  += int'(leds64[1]);
    end
    chk("duty0_on_count",   32'(on0),   32'd0);
    chk("duty256_on_count", 32'(on256), 32'd512);
    chk("duty64_on_count",  32'(on64),  32'd128);
    // Invalid code with enable low/high, then 7->1 recovery.
    for (int i = 0; i < 4; i++) step(7, 1'b0, 1'b0, 1'b1);
    step(7, 1'b0, 1'b1, 1'b1);
    hold(7, 4);
    hold(1, 3);
    // Randomised traffic.
    cur = 1;
    for (int i = 0; i < 400; i++) begin
      cur = ($urandom_range(0, 9) < 7) ? next_legal(cur) : int'($urandom_range(0, 7));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++)
        step(cur, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), 1'b1);
    end
    // Asynchronous reset mid-run with step_count=3 and red lit.
    step(1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) hold(c, 3);
    @(negedge clk);
    #1;
    chk("pre_reset_count", 32'(cnt128), 32'd3);
    chk("pre_reset_red",   32'(leds128), 32'b100);
    #1;
    rst = 1'b0;
    #1;
    chk("async_leds",  32'(leds128), 32'd0);
    chk("async_err",   32'(err128),  32'd0);
    chk("async_count", 32'(cnt128),  32'd0);
    step(4, 1'b1, 1'b0, 1'b0);
    hold(4, 4);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_led_driver.md
Name: rgb_led_driver

Overview:
- Receive-side consumer of the 3-bit colour code produced by the dynamic-lights block.
- Registers the code and drives three PWM-dimmed LED pins (red/green/blue).
- Checks that the incoming colour sequence obeys the lights protocol (hold, step +1, wrap to 1) and counts legal steps.
- Sits between the lights block and the board LED pins.

Parameters:
PWM_BITS, 8, width of the free-running PWM counter (period = 2^PWM_BITS cycles)
DUTY, 128, on-time per PWM period in clocks; values >= 2^PWM_BITS mean always on
CNT_WIDTH, 8, width of step_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
colour  input  3  colour code from the lights block; bit2=red, bit1=green, bit0=blue
enable  input  1  1 = LEDs may light; 0 = LEDs forced off
err_clr  input  1  single-cycle clear of seq_error
led_r  output  1  red LED drive, registered
led_g  output  1  green LED drive, registered
led_b  output  1  blue LED drive, registered
seq_error  output  1  sticky protocol-violation flag
step_count  output  CNT_WIDTH  number of legal colour changes since reset, saturating

Behaviour:
Reset (rst=0, asynchronous):
- colour_q = 3'b001 and prev_q = 3'b001, matching the lights reset value.
- pwm_cnt = 0; led_r/g/b = 0; seq_error = 0; step_count = 0.
- Reset asserted mid-operation takes effect immediately, with no clock required.

Input stage:
- colour_q <= colour every cycle.
- prev_q <= colour_q every cycle.

PWM:
- pwm_cnt increments every cycle while enable=1 and wraps from 2^PWM_BITS-1 to 0.
- While enable=0, pwm_cnt is held at 0.
- pwm_on = (pwm_cnt < DUTY). The compare is done in PWM_BITS+1 bits, so DUTY=0 gives never-on and DUTY>=2^PWM_BITS gives always-on.

LED outputs (registered):
- led_x <= colour_q[bit] & pwm_on & enable.
- colour_q==3'b000 or 3'b111 forces all three LEDs to 0; 7 is not a legal display colour.
- Latency from colour input to LED pin: 2 clocks.

Sequence checker (evaluated when colour_q != prev_q):
- Legal changes:
  - prev in 1..5 and new = prev+1
  - prev = 6 and new = 1
  - prev = 7 and new = 1 (recovery)
- A legal change increments step_count, saturating at all-ones with no wrap.
- Any other change sets seq_error. Examples: a skip, a decrement, any move to 0 or to 7, 1->1 is n/a (no change).
- No change (hold) is always legal and causes no count.
- err_clr=1 clears seq_error. If a new violation is detected in the same cycle, set wins and seq_error stays 1.
- The checker runs regardless of enable.

Optional Feature:
LEDDRV_WRAP_PULSE_EN:
- When defined, adds output port wrap_pulse (1 bit, reset 0).
- wrap_pulse is high for exactly one cycle, the cycle after a legal 6->1 change is detected.
- The 7->1 recovery change does not pulse.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 with colour=3'b101 -> led_r/g/b=0, seq_error=0, step_count=0. Release rst; 2 clocks later LEDs follow colour 101 with PWM duty 128/256.
- Full legal cycle: drive 1,2,3,4,5,6,1, each for 3 cycles, enable=1 -> step_count=6, seq_error=0. With LEDDRV_WRAP_PULSE_EN defined, exactly one wrap_pulse, on the 6->1 change.
- Violations: drive 2 then 4 -> seq_error=1 and step_count unchanged. Pulse err_clr -> 0. Then drive 4->3 -> seq_error=1. Assert err_clr in the same cycle as a 3->0 change -> seq_error remains 1.
- PWM extremes: with colour=3'b010, enable=1:
  - DUTY=0 -> led_g never 1 over 512 cycles.
  - DUTY=256 -> led_g constantly 1.
  - DUTY=64 -> led_g high for 64 of every 256 cycles.
- Enable and invalid codes: enable=0 with colour=3'b111 -> all LEDs 0 and pwm_cnt stays 0. Re-enable -> LEDs stay 0 while colour=7. Drive 7->1 -> legal, step_count +1, no error.
- Async reset mid-run: assert rst between clock edges while LEDs are on and step_count=3 -> outputs 0 and step_count=0 immediately, before the next clock edge.
